// File: rtl/alarm_ctrl_if.sv
// alarm_ctrl_if: bundles the timekeeper inputs, user controls and alarm
// status outputs of alarm_ctrl.
//
// Protocol: there is no valid/ready handshake. sec_tick, set_alarm, arm,
// disarm, snooze and dismiss are single-cycle strobes, sampled on the rising
// clock edge. cur_hr/cur_min/cur_sec already show the new second on the
// cycle where sec_tick is high. All outputs are registered.
//
// Modports:
//   master - drives the time and control inputs, observes the status outputs
//   slave  - the controller itself
interface alarm_ctrl_if;
  logic       sec_tick;
  logic [4:0] cur_hr;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic       set_alarm;
  logic [4:0] set_hr;
  logic [5:0] set_min;
  logic       arm;
  logic       disarm;
  logic       snooze;
  logic       dismiss;
  logic       buzzer;
  logic [1:0] state_o;
  logic [4:0] alarm_hr_o;
  logic [5:0] alarm_min_o;
  logic [2:0] snooze_cnt;
  logic       set_err;

  modport master (
    output sec_tick, cur_hr, cur_min, cur_sec,
    output set_alarm, set_hr, set_min,
    output arm, disarm, snooze, dismiss,
    input  buzzer, state_o, alarm_hr_o, alarm_min_o, snooze_cnt, set_err
  );

  modport slave (
    input  sec_tick, cur_hr, cur_min, cur_sec,
    input  set_alarm, set_hr, set_min,
    input  arm, disarm, snooze, dismiss,
    output buzzer, state_o, alarm_hr_o, alarm_min_o, snooze_cnt, set_err
  );
endinterface

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: sequenced alarm controller (IDLE/ARMED/RINGING/SNOOZE).
//
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   bus  - alarm_ctrl_if.slave:
//            in : sec_tick, cur_hr/min/sec, set_alarm, set_hr/min,
//                 arm, disarm, snooze, dismiss
//            out: buzzer (1 while RINGING), state_o, alarm_hr_o/alarm_min_o,
//                 snooze_cnt, set_err (one-cycle pulse on a rejected load)
//
// The programmed alarm time (alarm_*) is separate from the match target
// (tgt_*): the target is copied from the alarm registers on arm/dismiss/
// timeout and is overwritten by cur+SNOOZE_MIN on a snooze, so reloading the
// alarm registers never disturbs a snooze in progress.
module alarm_ctrl #(
  parameter int SNOOZE_MIN   = 5,
  parameter int MAX_SNOOZE   = 3,
  parameter int RING_TIMEOUT = 60
) (
  input logic          clk,
  input logic          rst,
  alarm_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ARMED   = 2'b01,
    S_RINGING = 2'b10,
    S_SNOOZE  = 2'b11
  } state_t;

  localparam logic [6:0] SNOOZE_ADD = 7'(SNOOZE_MIN);
  localparam logic [2:0] SNOOZE_LIM = 3'(MAX_SNOOZE);
  localparam logic [7:0] RING_LIM   = 8'(RING_TIMEOUT);

  state_t     state_q, state_d;
  logic       buzzer_q, buzzer_d;
  logic [4:0] alarm_hr_q, alarm_hr_d;
  logic [5:0] alarm_min_q, alarm_min_d;
  logic [2:0] snooze_cnt_q, snooze_cnt_d;
  logic       set_err_q, set_err_d;
  logic [4:0] tgt_hr_q, tgt_hr_d;
  logic [5:0] tgt_min_q, tgt_min_d;
  logic [7:0] ring_cnt_q, ring_cnt_d;

  logic       set_ok;
  logic       match;
  logic [7:0] ring_inc;
  logic       timeout;
  logic [6:0] min_sum;
  logic [6:0] hr_sum;
  logic       do_disarm, do_dismiss, do_snooze, do_arm;

  always_comb begin
    set_ok = (bus.set_hr <= 5'd23) && (bus.set_min <= 6'd59);

    // Only second 0 matches, so a rearmed alarm cannot re-fire in the same minute.
    match = bus.sec_tick && (bus.cur_sec == 6'd0) &&
            (bus.cur_hr == tgt_hr_q) && (bus.cur_min == tgt_min_q);

    ring_inc = (ring_cnt_q == 8'hFF) ? ring_cnt_q : ring_cnt_q + 8'd1;
    timeout  = bus.sec_tick && (ring_inc >= RING_LIM);

    // Snooze target = current time + SNOOZE_MIN, computed at 7 bits so the
    // sums can be compared against 60/24 before wrapping.
    min_sum = {1'b0, bus.cur_min} + SNOOZE_ADD;
    hr_sum  = {2'b00, bus.cur_hr};
    if (min_sum >= 7'd60) begin
      min_sum = min_sum - 7'd60;
      hr_sum  = hr_sum + 7'd1;
    end
    if (hr_sum >= 7'd24) begin
      hr_sum = hr_sum - 7'd24;
    end

    // Coincident controls: disarm > dismiss > snooze > arm; losers are dropped.
    do_disarm  = bus.disarm;
    do_dismiss = bus.dismiss && !bus.disarm;
    do_snooze  = bus.snooze  && !bus.disarm && !bus.dismiss;
    do_arm     = bus.arm     && !bus.disarm && !bus.dismiss && !bus.snooze;
  end

  always_comb begin
    state_d      = state_q;
    alarm_hr_d   = alarm_hr_q;
    alarm_min_d  = alarm_min_q;
    snooze_cnt_d = snooze_cnt_q;
    set_err_d    = 1'b0;
    tgt_hr_d     = tgt_hr_q;
    tgt_min_d    = tgt_min_q;
    ring_cnt_d   = ring_cnt_q;

    if (bus.set_alarm) begin
      if (set_ok) begin
        alarm_hr_d  = bus.set_hr;
        alarm_min_d = bus.set_min;
      end else begin
        set_err_d = 1'b1;
      end
    end

    if (do_disarm) begin
      state_d      = S_IDLE;
      snooze_cnt_d = 3'd0;
      ring_cnt_d   = 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (do_arm) begin
            state_d   = S_ARMED;
            tgt_hr_d  = alarm_hr_q;
            tgt_min_d = alarm_min_q;
          end
        end
        S_ARMED: begin
          if (match) begin
            state_d    = S_RINGING;
            ring_cnt_d = 8'd0;
          end
        end
        S_RINGING: begin
          if (bus.sec_tick) begin
            ring_cnt_d = ring_inc;
          end
          if (do_dismiss || (!(do_snooze && (snooze_cnt_q < SNOOZE_LIM)) && timeout)) begin
            // Dismiss and ring timeout both return to the programmed alarm.
            state_d      = S_ARMED;
            tgt_hr_d     = alarm_hr_q;
            tgt_min_d    = alarm_min_q;
            snooze_cnt_d = 3'd0;
          end else if (do_snooze && (snooze_cnt_q < SNOOZE_LIM)) begin
            state_d      = S_SNOOZE;
            snooze_cnt_d = snooze_cnt_q + 3'd1;
            tgt_hr_d     = hr_sum[4:0];
            tgt_min_d    = min_sum[5:0];
          end
        end
        S_SNOOZE: begin
          if (do_dismiss) begin
            state_d      = S_ARMED;
            tgt_hr_d     = alarm_hr_q;
            tgt_min_d    = alarm_min_q;
            snooze_cnt_d = 3'd0;
          end else if (match) begin
            state_d    = S_RINGING;
            ring_cnt_d = 8'd0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    buzzer_d = (state_d == S_RINGING);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      buzzer_q     <= 1'b0;
      alarm_hr_q   <= 5'd0;
      alarm_min_q  <= 6'd0;
      snooze_cnt_q <= 3'd0;
      set_err_q    <= 1'b0;
      tgt_hr_q     <= 5'd0;
      tgt_min_q    <= 6'd0;
      ring_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      buzzer_q     <= buzzer_d;
      alarm_hr_q   <= alarm_hr_d;
      alarm_min_q  <= alarm_min_d;
      snooze_cnt_q <= snooze_cnt_d;
      set_err_q    <= set_err_d;
      tgt_hr_q     <= tgt_hr_d;
      tgt_min_q    <= tgt_min_d;
      ring_cnt_q   <= ring_cnt_d;
    end
  end

  assign bus.buzzer      = buzzer_q;
  assign bus.state_o     = state_q;
  assign bus.alarm_hr_o  = alarm_hr_q;
  assign bus.alarm_min_o = alarm_min_q;
  assign bus.snooze_cnt  = snooze_cnt_q;
  assign bus.set_err     = set_err_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: self-checking bench for alarm_ctrl (SNOOZE_MIN=5,
// MAX_SNOOZE=3, RING_TIMEOUT=60). Table of single-cycle vectors plus
// hand-written multi-cycle sequences; every expectation goes through exp_q.
module tb_alarm_ctrl;

  localparam int W = 18;
  localparam int ST_IDLE = 0, ST_ARMED = 1, ST_RING = 2, ST_SNZ = 3;
  localparam int C_ARM = 8, C_DISARM = 4, C_SNZ = 2, C_DMS = 1;
  localparam int N_TBL = 9;

  typedef struct {
    logic         tick;
    logic [4:0]   hr;
    logic [5:0]   mn;
    logic [5:0]   sc;
    logic [3:0]   ctl;
    logic         sa;
    logic [4:0]   shr;
    logic [5:0]   smn;
    logic [W-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  logic [W-1:0] exp_q[$];
  vec_t tbl[N_TBL];

  alarm_ctrl_if bus();

  alarm_ctrl #(.SNOOZE_MIN(5), .MAX_SNOOZE(3), .RING_TIMEOUT(60)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] pack(input int st, input int bz, input int ah,
                                        input int am, input int cnt, input int er);
    return {2'(st), 1'(bz), 5'(ah), 6'(am), 3'(cnt), 1'(er)};
  endfunction

  function automatic vec_t mk(input int tk, input int hr, input int mn, input int sc,
                              input int ctl, input int sa, input int shr, input int smn,
                              input int est, input int ebz, input int eah, input int eam,
                              input int ecnt, input int eer);
    vec_t v;
    v.tick = 1'(tk);
    v.hr   = 5'(hr);
    v.mn   = 6'(mn);
    v.sc   = 6'(sc);
    v.ctl  = 4'(ctl);
    v.sa   = 1'(sa);
    v.shr  = 5'(shr);
    v.smn  = 6'(smn);
    v.exp  = pack(est, ebz, eah, eam, ecnt, eer);
    return v;
  endfunction

  function automatic logic [W-1:0] dut_word();
    return {bus.state_o, bus.buzzer, bus.alarm_hr_o, bus.alarm_min_o,
            bus.snooze_cnt, bus.set_err};
  endfunction

  // ---------------- driver ----------------
  task automatic clear_pulses();
    bus.sec_tick  = 1'b0;
    bus.set_alarm = 1'b0;
    bus.arm       = 1'b0;
    bus.disarm    = 1'b0;
    bus.snooze    = 1'b0;
    bus.dismiss   = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    bus.sec_tick  = v.tick;
    bus.cur_hr    = v.hr;
    bus.cur_min   = v.mn;
    bus.cur_sec   = v.sc;
    bus.arm       = v.ctl[3];
    bus.disarm    = v.ctl[2];
    bus.snooze    = v.ctl[1];
    bus.dismiss   = v.ctl[0];
    bus.set_alarm = v.sa;
    bus.set_hr    = v.shr;
    bus.set_min   = v.smn;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_front(input string nm);
    logic [W-1:0] e, a;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: expected queue empty", nm);
    end else begin
      e = exp_q.pop_front();
      a = dut_word();
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got st=%0d buz=%0d ahr=%0d amin=%0d cnt=%0d err=%0d want st=%0d buz=%0d ahr=%0d amin=%0d cnt=%0d err=%0d",
                 nm, a[17:16], a[15], a[14:10], a[9:4], a[3:1], a[0],
                 e[17:16], e[15], e[14:10], e[9:4], e[3:1], e[0]);
      end
    end
  endtask

  // One clock: drive, push expectation, sample 1 time unit after the edge.
  task automatic run_vec(input vec_t v, input string nm);
    drive(v);
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    clear_pulses();
    check_front(nm);
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock edge.
  task automatic async_reset_check(input string nm);
    #2;
    rst = 1'b0;
    #1;
    exp_q.push_back(pack(ST_IDLE, 0, 0, 0, 0, 0));
    check_front(nm);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- test ----------------
  initial begin
    // Invalid loads, valid load, arm, arm-again, match at second 0, and a
    // rejected load while ringing (which also counts as ring tick 1).
    tbl[0] = mk(0, 7, 29, 59, 0,      1, 24, 10, ST_IDLE,  0, 0, 0,  0, 1);
    tbl[1] = mk(0, 7, 29, 59, 0,      0, 0,  0,  ST_IDLE,  0, 0, 0,  0, 0);
    tbl[2] = mk(0, 7, 29, 59, 0,      1, 7,  60, ST_IDLE,  0, 0, 0,  0, 1);
    tbl[3] = mk(0, 7, 29, 59, 0,      1, 7,  30, ST_IDLE,  0, 7, 30, 0, 0);
    tbl[4] = mk(0, 7, 29, 59, C_ARM,  0, 0,  0,  ST_ARMED, 0, 7, 30, 0, 0);
    tbl[5] = mk(0, 7, 29, 59, C_ARM,  0, 0,  0,  ST_ARMED, 0, 7, 30, 0, 0);
    tbl[6] = mk(1, 7, 29, 59, 0,      0, 0,  0,  ST_ARMED, 0, 7, 30, 0, 0);
    tbl[7] = mk(1, 7, 30, 0,  0,      0, 0,  0,  ST_RING,  1, 7, 30, 0, 0);
    tbl[8] = mk(1, 7, 30, 1,  0,      1, 31, 0,  ST_RING,  1, 7, 30, 0, 1);

    clear_pulses();
    bus.cur_hr  = 5'd0;
    bus.cur_min = 6'd0;
    bus.cur_sec = 6'd0;
    bus.set_hr  = 5'd0;
    bus.set_min = 6'd0;

    #2;
    exp_q.push_back(pack(ST_IDLE, 0, 0, 0, 0, 0));
    check_front("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < N_TBL; i++) begin
      run_vec(tbl[i], $sformatf("tbl%0d", i));
    end

    // Ticks 2..59 keep ringing; the 60th tick (07:31:00) times out.
    for (int s = 2; s < 60; s++) begin
      run_vec(mk(1, 7, 30, s, 0, 0, 0, 0, ST_RING, 1, 7, 30, 0, 0), $sformatf("ring_hold_%0d", s));
    end
    run_vec(mk(1, 7, 31, 0,  0, 0, 0, 0, ST_ARMED, 0, 7, 30, 0, 0), "timeout");
    run_vec(mk(1, 7, 29, 59, 0, 0, 0, 0, ST_ARMED, 0, 7, 30, 0, 0), "next_day_pre");
    run_vec(mk(1, 7, 30, 0,  0, 0, 0, 0, ST_RING,  1, 7, 30, 0, 0), "next_day_ring");
    run_vec(mk(0, 7, 30, 0, C_DMS + C_SNZ, 0, 0, 0, ST_ARMED, 0, 7, 30, 0, 0), "dismiss_over_snooze");

    // Program 23:58 and re-arm so the target picks it up.
    run_vec(mk(0, 7, 30, 0,  0,        1, 23, 58, ST_ARMED, 0, 23, 58, 0, 0), "load_2358");
    run_vec(mk(0, 7, 30, 0,  C_DISARM, 0, 0,  0,  ST_IDLE,  0, 23, 58, 0, 0), "disarm");
    run_vec(mk(0, 7, 30, 0,  C_ARM,    0, 0,  0,  ST_ARMED, 0, 23, 58, 0, 0), "rearm");
    run_vec(mk(1, 23, 58, 0, 0,        0, 0,  0,  ST_RING,  1, 23, 58, 0, 0), "ring_2358");

    // Snooze across midnight: target 00:03, then 00:08, then 00:13.
    run_vec(mk(0, 23, 58, 0, C_SNZ, 0, 0, 0, ST_SNZ,  0, 23, 58, 1, 0), "snooze1");
    run_vec(mk(1, 23, 59, 0, 0,     0, 0, 0, ST_SNZ,  0, 23, 58, 1, 0), "snooze1_wait");
    run_vec(mk(1, 0,  2, 59, 0,     0, 0, 0, ST_SNZ,  0, 23, 58, 1, 0), "snooze1_pre");
    run_vec(mk(1, 0,  3, 0,  0,     0, 0, 0, ST_RING, 1, 23, 58, 1, 0), "snooze_wrap");
    run_vec(mk(0, 0,  3, 0,  C_SNZ, 0, 0, 0, ST_SNZ,  0, 23, 58, 2, 0), "snooze2");
    run_vec(mk(1, 0,  8, 0,  0,     0, 0, 0, ST_RING, 1, 23, 58, 2, 0), "snooze2_ring");
    run_vec(mk(0, 0,  8, 0,  C_SNZ, 0, 0, 0, ST_SNZ,  0, 23, 58, 3, 0), "snooze3");
    run_vec(mk(1, 0, 13, 0,  0,     0, 0, 0, ST_RING, 1, 23, 58, 3, 0), "snooze3_ring");
    run_vec(mk(0, 0, 13, 0,  C_SNZ, 0, 0, 0, ST_RING, 1, 23, 58, 3, 0), "snooze_limit");
    run_vec(mk(0, 0, 13, 0,  C_DMS, 0, 0, 0, ST_ARMED, 0, 23, 58, 0, 0), "dismiss_ring");

    // Dismiss from SNOOZE, then disarm beating snooze while ringing.
    run_vec(mk(1, 23, 58, 0, 0,     0, 0, 0, ST_RING,  1, 23, 58, 0, 0), "ring_again");
    run_vec(mk(0, 23, 58, 0, C_SNZ, 0, 0, 0, ST_SNZ,   0, 23, 58, 1, 0), "snooze_a");
    run_vec(mk(0, 23, 58, 0, C_DMS, 0, 0, 0, ST_ARMED, 0, 23, 58, 0, 0), "dismiss_snooze");
    run_vec(mk(1, 23, 58, 0, 0,     0, 0, 0, ST_RING,  1, 23, 58, 0, 0), "ring_b");
    run_vec(mk(0, 23, 58, 0, C_SNZ, 0, 0, 0, ST_SNZ,   0, 23, 58, 1, 0), "snooze_b");
    run_vec(mk(1, 0,  3, 0,  0,     0, 0, 0, ST_RING,  1, 23, 58, 1, 0), "ring_b2");
    run_vec(mk(0, 0,  3, 0,  C_DISARM + C_SNZ, 0, 0, 0, ST_IDLE, 0, 23, 58, 0, 0), "disarm_over_snooze");

    // Asynchronous reset mid-SNOOZE.
    run_vec(mk(0, 0,  3, 0,  C_ARM, 0, 0, 0, ST_ARMED, 0, 23, 58, 0, 0), "arm_c");
    run_vec(mk(1, 23, 58, 0, 0,     0, 0, 0, ST_RING,  1, 23, 58, 0, 0), "ring_c");
    run_vec(mk(0, 23, 58, 0, C_SNZ, 0, 0, 0, ST_SNZ,   0, 23, 58, 1, 0), "snooze_c");
    async_reset_check("async_rst_snooze");

    // Asynchronous reset mid-ring: alarm regs are 00:00 after reset.
    run_vec(mk(0, 23, 59, 0, C_ARM, 0, 0, 0, ST_ARMED, 0, 0, 0, 0, 0), "arm_d");
    run_vec(mk(1, 0,  0,  0, 0,     0, 0, 0, ST_RING,  1, 0, 0, 0, 0), "ring_d");
    async_reset_check("async_rst_ring");

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover: got %0d queued entries want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
Alarm sequencing controller for the FPGA clock/alarm design. Takes the running hr/min/sec values and a one-cycle seconds tick from the timekeeper, and holds the programmed alarm time. Runs an IDLE/ARMED/RINGING/SNOOZE state machine with snooze-limit and ring-timeout rules, and drives the buzzer. It replaces the simple hr/min equality alarm with a sequenced controller.

Parameters:
SNOOZE_MIN, 5, minutes added per snooze; legal range 1..59.
MAX_SNOOZE, 3, maximum snoozes per alarm event; legal range 0..7.
RING_TIMEOUT, 60, seconds of ringing before auto-stop; legal range 1..255.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset (asserted when 0)
sec_tick  input  1  one-clk pulse; cur_* already hold the new second on this cycle
cur_hr  input  5  current hour, 0..23
cur_min  input  6  current minute, 0..59
cur_sec  input  6  current second, 0..59
set_alarm  input  1  one-clk strobe; load set_hr/set_min
set_hr  input  5  alarm hour to load
set_min  input  6  alarm minute to load
arm  input  1  one-clk pulse; enable alarm
disarm  input  1  one-clk pulse; disable alarm
snooze  input  1  one-clk pulse; snooze while ringing
dismiss  input  1  one-clk pulse; stop ringing or snoozing
buzzer  output  1  registered; 1 while RINGING
state_o  output  2  00 IDLE, 01 ARMED, 10 RINGING, 11 SNOOZE
alarm_hr_o  output  5  programmed alarm hour
alarm_min_o  output  6  programmed alarm minute
snooze_cnt  output  3  snoozes taken in the current event
set_err  output  1  one-clk pulse; rejected set_alarm

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, buzzer 0, alarm_hr_o 0, alarm_min_o 0, snooze_cnt 0, set_err 0, target 00:00, ring counter 0.
- set_alarm: if set_hr<=23 and set_min<=59, load both registers on the next edge, in any state. The target is not changed, so an active snooze is unaffected. Otherwise keep the old values and pulse set_err high for 1 cycle.
- Control priority when pulses coincide: disarm > dismiss > snooze > arm. Only the highest-priority pulse is acted on; the others are dropped.
- IDLE: arm -> ARMED. Target is loaded with alarm_hr_o/alarm_min_o.
- ARMED: goes to RINGING on a cycle where sec_tick=1, cur_sec==0, cur_hr==target_hr and cur_min==target_min. The ring counter is cleared. Matching only at second 0 prevents a re-trigger inside the same minute.
- RINGING:
  - Ring counter increments on each sec_tick.
  - dismiss -> ARMED. Target reloads from the alarm registers; snooze_cnt clears.
  - snooze with snooze_cnt<MAX_SNOOZE -> SNOOZE. snooze_cnt increments. Target becomes cur + SNOOZE_MIN: minute sum >=60 subtracts 60 and carries to the hour; hour 24 wraps to 0.
  - snooze with snooze_cnt==MAX_SNOOZE is ignored; ringing continues.
  - When the ring counter reaches RING_TIMEOUT on a sec_tick -> ARMED, same as dismiss.
- SNOOZE:
  - The same match rule as ARMED, against the snooze target, -> RINGING with the ring counter cleared.
  - dismiss -> ARMED, same as from RINGING.
- disarm in any state -> IDLE. buzzer clears on the next edge; snooze_cnt clears.
- arm outside IDLE has no effect.
- buzzer is registered: it is 1 exactly while state_o==RINGING, with the same-edge update as state.
- Ring counter is 8 bits and saturates. All time arithmetic is done at 7 bits to avoid overflow before the wrap compare.
- Reset asserted mid-ring: buzzer drops immediately (asynchronously) and the block returns to IDLE.

Test Plan:
1. Load 07:30, arm. Drive cur to 07:29:59, then tick to 07:30:00 -> state RINGING, buzzer=1 on the next edge. Ticks at 07:30:01..07:30:59 cause no further transition.
2. Ringing at 23:58:00, snooze with SNOOZE_MIN=5 -> SNOOZE, target 00:03, snooze_cnt=1. Tick to 00:03:00 -> RINGING again.
3. Snooze MAX_SNOOZE=3 times, ring again, snooze -> remains RINGING, snooze_cnt=3. Dismiss -> ARMED, snooze_cnt=0, buzzer=0.
4. Ring with no input for 60 ticks -> ARMED and buzzer=0 after tick 60. The matching time on the next day rings again.
5. set_alarm with set_hr=24, set_min=10 -> set_err pulses once and alarm regs are unchanged. set_min=60 is also rejected.
6. Same-cycle disarm+snooze while RINGING -> IDLE, snooze_cnt=0. Assert rst mid-SNOOZE -> all outputs at reset values without waiting for a clk edge.
